// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi traceback block and its argmax helper.
package viterbi_pkg;

  localparam int I     = 3;
  localparam int W     = 20;
  localparam int T_MAX = 16;
  localparam int SW    = $clog2(I);
  localparam int LW    = $clog2(T_MAX + 1);
  localparam int AW    = $clog2(T_MAX);

  typedef enum logic [1:0] {
    COLLECT,
    ARGMAX,
    TRACE
  } tb_state_e;

  typedef logic signed [W-1:0] delta_t;

  // Backpointers that name a non-existent state fall back to state 0.
  function automatic logic [SW-1:0] clampState(input logic [SW-1:0] s);
    return (int'(s) >= I) ? '0 : s;
  endfunction

endpackage

// File: rtl/viterbi_argmax.sv
// Combinational I-way signed argmax; ties resolve to the lowest index.
module viterbi_argmax
  import viterbi_pkg::*;
(
  input  logic [W*I-1:0] delta_flat_i,
  output logic [SW-1:0]  best_idx_o,
  output delta_t         best_val_o
);

  delta_t         bestVal;
  logic [SW-1:0]  bestIdx;

  // Strict greater-than keeps the earliest maximum.
  always_comb begin
    bestVal = $signed(delta_flat_i[0 +: W]);
    bestIdx = '0;
    for (int j = 1; j < I; j++) begin
      if ($signed(delta_flat_i[j*W +: W]) > bestVal) begin
        bestVal = $signed(delta_flat_i[j*W +: W]);
        bestIdx = SW'(j);
      end
    end
  end

  assign best_idx_o = bestIdx;
  assign best_val_o = bestVal;

endmodule

// File: rtl/viterbi_traceback.sv
// Viterbi backpointer buffer and traceback streamer.
// Optional `VITERBI_TB_SCORE_EN adds out_score, the best terminal delta.
module viterbi_traceback
  import viterbi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [I*SW-1:0]   in_psi_flat,
  input  logic [W*I-1:0]    in_delta_flat,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SW-1:0]     out_state,
  output logic              out_last,
  output logic              busy,
  output logic              err_overflow
`ifdef VITERBI_TB_SCORE_EN
  ,
  output delta_t            out_score
`endif
);

  tb_state_e          state_q, state_d;
  logic [LW-1:0]      wrPtr_q, wrPtr_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      rdPtr_q, rdPtr_d;
  logic [SW-1:0]      curState_q, curState_d;
  logic [W*I-1:0]     delta_q, delta_d;
  logic               err_q, err_d;
  logic               memWe;
  logic [I*SW-1:0]    mem_q [T_MAX];
  logic [I*SW-1:0]    psiRow;
  logic [SW-1:0]      nextState;
  logic [SW-1:0]      bestIdx;
  delta_t             bestVal;
`ifdef VITERBI_TB_SCORE_EN
  delta_t             score_q, score_d;
`endif

  viterbi_argmax uArgmax (
    .delta_flat_i (delta_q),
    .best_idx_o   (bestIdx),
    .best_val_o   (bestVal)
  );

  assign psiRow    = mem_q[rdPtr_q[AW-1:0]];
  assign nextState = clampState(psiRow[curState_q*SW +: SW]);

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem_q[wrPtr_q[AW-1:0]] <= in_psi_flat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      wrPtr_q    <= '0;
      len_q      <= '0;
      rdPtr_q    <= '0;
      curState_q <= '0;
      delta_q    <= '0;
      err_q      <= 1'b0;
`ifdef VITERBI_TB_SCORE_EN
      score_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      len_q      <= len_d;
      rdPtr_q    <= rdPtr_d;
      curState_q <= curState_d;
      delta_q    <= delta_d;
      err_q      <= err_d;
`ifdef VITERBI_TB_SCORE_EN
      score_q    <= score_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    len_d      = len_q;
    rdPtr_d    = rdPtr_q;
    curState_d = curState_q;
    delta_d    = delta_q;
    err_d      = err_q;
`ifdef VITERBI_TB_SCORE_EN
    score_d    = score_q;
`endif
    memWe      = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_state  = '0;
    out_last   = 1'b0;
    busy       = 1'b0;

    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          memWe   = 1'b1;
          wrPtr_d = wrPtr_q + LW'(1);
          if (wrPtr_q == '0) begin
            err_d = 1'b0;
          end
          // A full buffer ends the sequence as if in_last had arrived.
          if (in_last || (wrPtr_q == LW'(T_MAX - 1))) begin
            delta_d = in_delta_flat;
            len_d   = wrPtr_q + LW'(1);
            state_d = ARGMAX;
            if (!in_last) begin
              err_d = 1'b1;
            end
          end
        end
      end

      ARGMAX: begin
        busy       = 1'b1;
        curState_d = bestIdx;
        rdPtr_d    = len_q - LW'(1);
`ifdef VITERBI_TB_SCORE_EN
        score_d    = bestVal;
`endif
        state_d    = TRACE;
      end

      TRACE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_state = curState_q;
        out_last  = (rdPtr_q == '0);
        if (out_ready) begin
          if (rdPtr_q == '0) begin
            state_d = COLLECT;
            wrPtr_d = '0;
          end else begin
            curState_d = nextState;
            rdPtr_d    = rdPtr_q - LW'(1);
          end
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign err_overflow = err_q;
`ifdef VITERBI_TB_SCORE_EN
  assign out_score = score_q;
`else
  logic unusedBestVal;
  assign unusedBestVal = ^bestVal;
`endif

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed self-checking bench for viterbi_traceback (optionally with VITERBI_TB_SCORE_EN).
module tb_viterbi_traceback;
  import viterbi_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [I*SW-1:0]   in_psi_flat;
  logic [W*I-1:0]    in_delta_flat;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_state;
  logic              out_last;
  logic              busy;
  logic              err_overflow;
`ifdef VITERBI_TB_SCORE_EN
  delta_t            out_score;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [SW-1:0] NOM [4] = '{2'd1, 2'd0, 2'd1, 2'd0};

  always #5 clk = ~clk;

  viterbi_traceback dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_psi_flat   (in_psi_flat),
    .in_delta_flat (in_delta_flat),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_state     (out_state),
    .out_last      (out_last),
    .busy          (busy),
    .err_overflow  (err_overflow)
`ifdef VITERBI_TB_SCORE_EN
    ,
    .out_score     (out_score)
`endif
  );

  function automatic logic [I*SW-1:0] packPsi(input int p0, input int p1, input int p2);
    return {SW'(p2), SW'(p1), SW'(p0)};
  endfunction

  function automatic logic [W*I-1:0] packDelta(input int d0, input int d1, input int d2);
    return {W'(d2), W'(d1), W'(d0)};
  endfunction

  // Presents one step for exactly one edge; caller ensures COLLECT.
  task automatic applyStimulus(input logic [I*SW-1:0] psi, input logic [W*I-1:0] delta,
                               input logic last);
    in_valid      = 1'b1;
    in_psi_flat   = psi;
    in_delta_flat = delta;
    in_last       = last;
    @(posedge clk); #1;
    in_valid      = 1'b0;
    in_last       = 1'b0;
  endtask

  task automatic loadNominal();
    applyStimulus(packPsi(3, 1, 2), '0, 1'b0);
    applyStimulus(packPsi(2, 0, 1), '0, 1'b0);
    applyStimulus(packPsi(1, 2, 0), '0, 1'b0);
    applyStimulus(packPsi(0, 0, 2), packDelta(-10, 5, 3), 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_state !== 2'd0) begin errors++; $display("[TB] FAIL rst_out_state: got %0d expected 0", out_state); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_last: got %b expected 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b expected 0", err_overflow); end
`ifdef VITERBI_TB_SCORE_EN
    checks++; if (out_score !== delta_t'(0)) begin errors++; $display("[TB] FAIL rst_score: got %0d expected 0", out_score); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    out_ready = 1'b1;
    loadNominal();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL nom_argmax_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL nom_argmax_busy: got %b expected 1", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL nom_argmax_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL nom_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_state !== NOM[i]) begin errors++; $display("[TB] FAIL nom_state[%0d]: got %0d expected %0d", i, out_state, NOM[i]); end
      checks++; if (out_last !== (i == 3)) begin errors++; $display("[TB] FAIL nom_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL nom_trace_ready[%0d]: got %b expected 0", i, in_ready); end
`ifdef VITERBI_TB_SCORE_EN
      checks++; if (out_score !== delta_t'(5)) begin errors++; $display("[TB] FAIL nom_score[%0d]: got %0d expected 5", i, out_score); end
`endif
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL nom_end_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL nom_end_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nom_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    loadNominal();
    @(posedge clk); #1;
    checks++; if (out_state !== 2'd1) begin errors++; $display("[TB] FAIL bp_first: got %0d expected 1", out_state); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b expected 1", k, out_valid); end
      checks++; if (out_state !== 2'd0) begin errors++; $display("[TB] FAIL bp_hold_state[%0d]: got %0d expected 0", k, out_state); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold_last[%0d]: got %b expected 0", k, out_last); end
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_state !== NOM[i]) begin errors++; $display("[TB] FAIL bp_state[%0d]: got %0d expected %0d", i, out_state, NOM[i]); end
      checks++; if (out_last !== (i == 3)) begin errors++; $display("[TB] FAIL bp_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
      @(posedge clk); #1;
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_end_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus(packPsi(1, 1, 1), '0, 1'b0);
    applyStimulus(packPsi(1, 1, 1), packDelta(0, 9, 0), 1'b0);
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_err: got %b expected 1", err_overflow); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ovf_busy: got %b expected 1", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_state !== 2'd1) begin errors++; $display("[TB] FAIL ovf_state[%0d]: got %0d expected 1", i, out_state); end
      checks++; if (out_last !== (i == 15)) begin errors++; $display("[TB] FAIL ovf_last[%0d]: got %b expected %b", i, out_last, (i == 15)); end
      @(posedge clk); #1;
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ovf_end_ready: got %b expected 1", in_ready); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", err_overflow); end
  endtask

  task automatic test_tie_len1();
    out_ready = 1'b1;
    applyStimulus(packPsi(0, 0, 0), packDelta(7, 7, -2), 1'b1);
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("[TB] FAIL tie_err_clear: got %b expected 0", err_overflow); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL tie_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL tie_valid: got %b expected 1", out_valid); end
    checks++; if (out_state !== 2'd0) begin errors++; $display("[TB] FAIL tie_state: got %0d expected 0", out_state); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("[TB] FAIL tie_last: got %b expected 1", out_last); end
`ifdef VITERBI_TB_SCORE_EN
    checks++; if (out_score !== delta_t'(7)) begin errors++; $display("[TB] FAIL tie_score: got %0d expected 7", out_score); end
`endif
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL tie_end_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL tie_end_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL tie_end_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid_trace();
    out_ready = 1'b1;
    loadNominal();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (out_state !== 2'd0) begin errors++; $display("[TB] FAIL rmt_second: got %0d expected 0", out_state); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmt_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmt_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmt_busy: got %b expected 0", busy); end
`ifdef VITERBI_TB_SCORE_EN
    checks++; if (out_score !== delta_t'(0)) begin errors++; $display("[TB] FAIL rmt_score: got %0d expected 0", out_score); end
`endif
    test_nominal();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_psi_flat   = '0;
    in_delta_flat = '0;
    in_last       = 1'b0;
    out_ready     = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_overflow();
    test_tie_len1();
    test_reset_mid_trace();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/viterbi_traceback.md
Name: viterbi_traceback

Overview:
- Downstream consumer of the Viterbi PE array.
- Each cycle-step it collects the I backpointers psi[n,j] produced by the PEs and stores them in a local register-file buffer.
- On the final step it takes the I deltas, picks the best terminal state, then walks the buffer backwards and streams the decoded state path out over a valid/ready interface.

Parameters:
- I, 3, number of HMM states (matches the PE array).
- W, 20, signed fixed-point width of delta values.
- T_MAX, 16, maximum sequence length (buffer depth).
- Derived: SW = $clog2(I), state-index width; LW = $clog2(T_MAX+1), length/pointer width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  step data valid.
- in_ready  out  1  block can accept a step.
- in_psi_flat  in  I*SW  psi for states j=0..I-1; field j at [j*SW +: SW].
- in_delta_flat  in  W*I  signed delta[n,j]; field j at [j*W +: W]. Sampled only with in_last.
- in_last  in  1  final observation of the sequence.
- out_valid  out  1  decoded state valid.
- out_ready  in  1  sink accepts the state.
- out_state  out  SW  decoded state, emitted in reverse time order (t=N-1 first).
- out_last  out  1  marks the t=0 state.
- busy  out  1  high in ARGMAX/TRACE.
- err_overflow  out  1  sticky; sequence hit T_MAX without in_last.

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge):
  - State COLLECT, wr_ptr=0.
  - in_ready=1, out_valid=0, out_state=0, out_last=0, busy=0, err_overflow=0.
  - Buffer contents are not reset.
  - Reset mid-operation aborts the sequence with no further outputs.
- FSM states: COLLECT, ARGMAX, TRACE.
- COLLECT:
  - in_ready=1.
  - On in_valid&in_ready: mem[wr_ptr]<=in_psi_flat; wr_ptr++.
  - The first accepted step after COLLECT entry clears err_overflow.
  - If in_last: capture in_delta_flat, len<=wr_ptr+1, go to ARGMAX.
  - If wr_ptr==T_MAX-1 and !in_last: same as last (its delta is captured), and err_overflow<=1.
- ARGMAX (1 cycle):
  - in_ready=0.
  - Signed compare, strict greater-than scan j=0..I-1; ties resolve to the lowest index.
  - cur_state<=best, rd_ptr<=len-1, go to TRACE.
- TRACE:
  - in_ready=0, out_valid=1, out_state=cur_state, out_last=(rd_ptr==0).
  - On out_valid&out_ready:
    - If rd_ptr==0: go to COLLECT, wr_ptr=0.
    - Else: cur_state<=mem[rd_ptr][cur_state]; rd_ptr--.
  - out_state and out_last hold stable while out_ready=0.
- Buffer read is combinational from the register array.
- psi field values >= I are clamped to state 0.
- Entry 0's psi is stored but never dereferenced.
- Latency: in_last accepted at edge k, ARGMAX at k+1, first out_valid after edge k+2. With out_ready=1, N states take N cycles.
- Back-to-back sequences: in_ready re-asserts the cycle after the out_last handshake.
- Sequence of length 1: one output, with out_last=1.

Optional Feature:
- Macro: VITERBI_TB_SCORE_EN.
- When defined:
  - Extra port out_score (out, W, signed) carries the best terminal delta.
  - Registered in ARGMAX; held constant through TRACE; reset 0.
- When undefined: the port and register do not exist.

Decomposition:
- Shared package viterbi_pkg holds:
  - Constants I, W, T_MAX, SW, LW.
  - State typedef tb_state_e {COLLECT, ARGMAX, TRACE}.
  - Signed delta typedef.
- Natural sub-module: viterbi_argmax, a combinational I-way signed argmax with lowest-index tie-break. It is reusable by the PE array.

Test Plan:
- Nominal 4-step sequence (I=3). psi as (j0,j1,j2):
  - t0 any, t1=(2,0,1), t2=(1,2,0), t3=(0,0,2).
  - Final deltas (-10,5,3) with in_last.
  - Required: outputs 1,0,1,0; out_last only on the 4th; first out_valid 2 cycles after the last accept.
- Tie and length 1: a single step with in_last, deltas (7,7,-2) -> one output, state 0, out_last=1, busy drops next cycle.
- Backpressure: out_ready held low 3 cycles after the 2nd output of the nominal test -> out_valid=1 and out_state=0 stable; sequence completes unchanged.
- Overflow: 16 steps, all psi=(1,1,1), no in_last, 16th deltas (0,9,0):
  - Required: err_overflow=1; 16 outputs of state 1; err_overflow clears on the next sequence's first step.
- Reset mid-TRACE: rst_n=0 for 1 cycle after the 2nd output -> out_valid=0, in_ready=1 next cycle; a following nominal sequence decodes correctly.
- With VITERBI_TB_SCORE_EN: nominal test gives out_score=5 throughout TRACE; reset gives 0.
